mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
Two-requester memory arbiter and sequencer for the RV64 core. Shares one memory port between instruction fetch (IF) and load/store (LS). Captures one request, drives it to memory with a valid/ready handshake, and waits for the memory response. Returns the read data to the owning requester, aligned and extended for LS. Only one transaction is outstanding at a time.

Parameters:
XLEN, 64, data/address width
IF_STARVE_MAX, 4, consecutive LS grants allowed while IF waits before IF is forced a grant (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
if_req_valid  in  1  IF fetch request
if_req_ready  out  1  IF request accepted this cycle
if_addr  in  XLEN  fetch address, 4-byte aligned
if_resp_valid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  32  fetched instruction
ls_req_valid  in  1  LS request
ls_req_ready  out  1  LS request accepted this cycle
ls_addr  in  XLEN  byte address
ls_wen  in  1  1 = store, 0 = load
ls_dlen  in  3  funct3 encoding: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU
ls_wdata  in  XLEN  store data, unshifted
ls_resp_valid  out  1  one-cycle pulse, load data valid or store done
ls_rdata  out  XLEN  extended load data; 0 for stores
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  captured address
mem_wen  out  1  captured write enable (0 for IF)
mem_dlen  out  3  captured dlen (3'd2 for IF)
mem_wdata  out  XLEN  captured wdata (0 for IF)
mem_resp_valid  in  1  memory response or write acknowledge
mem_rdata  in  XLEN  aligned doubleword containing the address
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst=0): state IDLE; starve counter 0; owner IF. All outputs 0, including the registered mem_addr, mem_wen, mem_dlen, mem_wdata, if_rdata and ls_rdata. A reset in REQ or WAIT abandons the transaction; no resp pulse is produced.
- FSM states:
  - IDLE: if either req_valid is high, arbitrate. Assert the winner's req_ready combinationally (other ready = 0). Capture the request fields and owner, then go to REQ. If neither is valid, stay.
  - REQ: mem_req_valid = 1 with the captured fields held stable. On mem_req_ready go to WAIT.
  - WAIT: on mem_resp_valid, register the data into the owner's rdata, pulse the owner's resp_valid next cycle, and go to RESP.
  - RESP: resp_valid = 1 for exactly this cycle; go to IDLE. No new request is accepted in RESP.
- req_ready is 0 outside IDLE. mem_resp_valid is ignored outside WAIT.
- Arbitration: LS wins by default.
  - If both are valid and starve_cnt == IF_STARVE_MAX, IF wins.
  - starve_cnt increments on an LS grant while if_req_valid = 1, saturating at IF_STARVE_MAX.
  - It clears on an IF grant, or on an LS grant while if_req_valid = 0.
- Latency: accept at cycle 0, mem_req_valid at cycle 1. With mem_req_ready and mem_resp_valid both immediate, mem_resp_valid is sampled at cycle 2 and resp_valid pulses at cycle 3. Best-case throughput is 1 transaction per 4 cycles.
- IF data: if_rdata = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
- LS load data: off = addr[2:0]; sh = mem_rdata >> (8*off).
  - Take the low 8, 16, 32 or 64 bits of sh per dlen.
  - dlen 0/1/2 sign-extend to XLEN; dlen 4/5/6 zero-extend; dlen 3 uses sh as-is.
  - dlen 7 returns 0.
  - Misaligned accesses are not checked (the caller guarantees alignment).
- LS stores: ls_rdata = 0; resp pulse signals completion.

Test Plan:
- Single IF fetch, if_addr=0x80000004, mem_rdata=0x00500093_00000013, immediate ready/resp -> if_req_ready at cycle 0, mem_req_valid cycle 1, if_resp_valid cycle 3, if_rdata=0x00500093.
- LS load LB, ls_addr=0x80000003, mem_rdata=0x0000_0000_8000_0000 -> ls_rdata=0xFFFFFFFFFFFFFF80. Same with LBU -> 0x80. LWU at 0x80000004 of 0xDEADBEEF_00000000 -> 0x00000000DEADBEEF.
- Both valid continuously, IF_STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF. The other requester's ready is never high in the same cycle.
- Stall: mem_req_ready low 5 cycles, then mem_resp_valid delayed 3 cycles -> mem_req_valid and fields stable throughout. Exactly one resp pulse; a spurious mem_resp_valid during REQ is ignored.
- Store SD, ls_wdata=0x1122334455667788 -> mem_wen=1, mem_dlen=3, mem_wdata unchanged; ls_resp_valid pulse with ls_rdata=0.
- rst driven low mid-WAIT -> all outputs 0 immediately (asynchronous). After release, the next request starts in IDLE and no stale resp pulse appears.

Source files
------------

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester, memory and status signals of the IF/LS memory arbiter
interface mem_arb_if #(
    parameter int XLEN = 64
);
    logic            if_req_valid;
    logic            if_req_ready;
    logic [XLEN-1:0] if_addr;
    logic            if_resp_valid;
    logic [31:0]     if_rdata;

    logic            ls_req_valid;
    logic            ls_req_ready;
    logic [XLEN-1:0] ls_addr;
    logic            ls_wen;
    logic [2:0]      ls_dlen;
    logic [XLEN-1:0] ls_wdata;
    logic            ls_resp_valid;
    logic [XLEN-1:0] ls_rdata;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [2:0]      mem_dlen;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_rdata;

    logic            busy;

    // Arbiter side
    modport slave (
        input  if_req_valid, if_addr,
        input  ls_req_valid, ls_addr, ls_wen, ls_dlen, ls_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_dlen, mem_wdata,
        output busy
    );

    // Requesters plus memory, seen from outside the arbiter
    modport master (
        output if_req_valid, if_addr,
        output ls_req_valid, ls_addr, ls_wen, ls_dlen, ls_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_dlen, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-outstanding IF/LS memory arbiter with starvation guard and load extension
module mem_arb #(
    parameter int XLEN          = 64,
    parameter int IF_STARVE_MAX = 4
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_LS     = 1'b1;
    localparam logic [3:0] STARVE_MAX = 4'(IF_STARVE_MAX);

    state_t          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic            owner_q, owner_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [2:0]      dlen_q, dlen_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;

    logic            if_ready, ls_ready, ls_wins;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] load_ext;

    // Shift the returned doubleword down to the addressed byte, then size and extend it
    always_comb begin
        sh = bus.mem_rdata >> {addr_q[2:0], 3'b000};
        case (dlen_q)
            3'd0:    load_ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'd1:    load_ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'd2:    load_ext = {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'd3:    load_ext = sh;
            3'd4:    load_ext = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'd5:    load_ext = {{(XLEN-16){1'b0}}, sh[15:0]};
            3'd6:    load_ext = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: load_ext = '0;
        endcase
    end

    // LS wins unless IF has waited through STARVE_MAX consecutive LS grants
    assign ls_wins = bus.ls_req_valid && !(bus.if_req_valid && (starve_q == STARVE_MAX));

    // Next-state, capture and handshake decode
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        dlen_d     = dlen_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_ready   = 1'b0;
        ls_ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // rst gating keeps the readies low while reset is asserted
                if (rst && (bus.if_req_valid || bus.ls_req_valid)) begin
                    state_d = S_REQ;
                    if (ls_wins) begin
                        ls_ready = 1'b1;
                        owner_d  = OWN_LS;
                        addr_d   = bus.ls_addr;
                        wen_d    = bus.ls_wen;
                        dlen_d   = bus.ls_dlen;
                        wdata_d  = bus.ls_wdata;
                        if (!bus.if_req_valid)
                            starve_d = 4'd0;
                        else if (starve_q != STARVE_MAX)
                            starve_d = starve_q + 4'd1;
                    end else begin
                        if_ready = 1'b1;
                        owner_d  = OWN_IF;
                        addr_d   = bus.if_addr;
                        wen_d    = 1'b0;
                        dlen_d   = 3'd2;
                        wdata_d  = '0;
                        starve_d = 4'd0;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_d = S_RESP;
                    if (owner_q == OWN_IF)
                        if_rdata_d = addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                    else
                        ls_rdata_d = wen_q ? '0 : load_ext;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-request registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            starve_q   <= 4'd0;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            dlen_q     <= 3'd0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            dlen_q     <= dlen_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.if_req_ready  = if_ready;
    assign bus.ls_req_ready  = ls_ready;
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.if_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IF);
    assign bus.ls_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LS);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_dlen      = dlen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.if_rdata      = if_rdata_q;
    assign bus.ls_rdata      = ls_rdata_q;
    assign bus.busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed self-checking bench for mem_arb
module tb_mem_arb;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   n;
    int   pulses;

    mem_arb_if #(.XLEN(64)) bus ();

    mem_arb #(.XLEN(64), .IF_STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn_if(input string tag, input logic [63:0] addr, input logic [63:0] mrdata,
                          input logic [31:0] exp);
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = addr;
        bus.mem_rdata    = mrdata;
        #1;
        check({tag, "_if_ready_c0"}, bus.if_req_ready, 1);
        check({tag, "_ls_ready_c0"}, bus.ls_req_ready, 0);
        tick();
        bus.if_req_valid = 1'b0;
        #1;
        check({tag, "_mreq_c1"}, bus.mem_req_valid, 1);
        check({tag, "_maddr"}, bus.mem_addr, addr);
        check({tag, "_mdlen"}, bus.mem_dlen, 2);
        check({tag, "_mwen"}, bus.mem_wen, 0);
        tick();
        #1;
        check({tag, "_resp_c2"}, bus.if_resp_valid, 0);
        tick();
        #1;
        check({tag, "_resp_c3"}, bus.if_resp_valid, 1);
        check({tag, "_rdata"}, bus.if_rdata, exp);
    endtask

    task automatic txn_ls(input string tag, input logic [63:0] addr, input logic wen, input logic [2:0] dlen,
                          input logic [63:0] wdata, input logic [63:0] mrdata, input logic [63:0] exp);
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = addr;
        bus.ls_wen       = wen;
        bus.ls_dlen      = dlen;
        bus.ls_wdata     = wdata;
        bus.mem_rdata    = mrdata;
        #1;
        check({tag, "_ls_ready"}, bus.ls_req_ready, 1);
        tick();
        bus.ls_req_valid = 1'b0;
        #1;
        check({tag, "_mreq"}, bus.mem_req_valid, 1);
        check({tag, "_maddr"}, bus.mem_addr, addr);
        check({tag, "_mwen"}, bus.mem_wen, wen);
        check({tag, "_mdlen"}, bus.mem_dlen, dlen);
        check({tag, "_mwdata"}, bus.mem_wdata, wdata);
        tick();
        tick();
        #1;
        check({tag, "_resp"}, bus.ls_resp_valid, 1);
        check({tag, "_rdata"}, bus.ls_rdata, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.if_req_valid   = 1'b0;
        bus.if_addr        = '0;
        bus.ls_req_valid   = 1'b0;
        bus.ls_addr        = '0;
        bus.ls_wen         = 1'b0;
        bus.ls_dlen        = 3'd0;
        bus.ls_wdata       = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_mreq", bus.mem_req_valid, 0);
        check("rst_maddr", bus.mem_addr, 0);
        check("rst_ifdata", bus.if_rdata, 0);
        check("rst_lsdata", bus.ls_rdata, 0);
        tick();
        rst = 1'b1;

        // Fetch from the upper word
        txn_if("if0", 64'h8000_0004, 64'h0050_0093_0000_0013, 32'h0050_0093);
        tick();
        check("if0_resp_c4", bus.if_resp_valid, 0);
        check("if0_idle_c4", bus.busy, 0);

        // Load alignment and extension
        txn_ls("lb",  64'h8000_0003, 1'b0, 3'd0, 64'h0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        txn_ls("lbu", 64'h8000_0003, 1'b0, 3'd4, 64'h0, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        txn_ls("lwu", 64'h8000_0004, 1'b0, 3'd6, 64'h0, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF);
        txn_ls("lh",  64'h8000_0006, 1'b0, 3'd1, 64'h0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        txn_ls("lhu", 64'h8000_0002, 1'b0, 3'd5, 64'h0, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D);
        txn_ls("lw",  64'h8000_0000, 1'b0, 3'd2, 64'h0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000);
        txn_ls("ld",  64'h8000_0008, 1'b0, 3'd3, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        txn_ls("d7",  64'h8000_0000, 1'b0, 3'd7, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0);
        txn_ls("ld2", 64'h8000_0010, 1'b0, 3'd3, 64'h0, 64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0001);
        txn_ls("sd",  64'h8000_0018, 1'b1, 3'd3, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);

        // Both requesters continuously valid: four LS grants, then IF
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0;
        tick();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0100;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_0200;
        bus.ls_wen       = 1'b0;
        bus.ls_dlen      = 3'd3;
        for (int g = 0; g < 10; g++) begin
            #1;
            n = 0;
            while (!(bus.if_req_ready || bus.ls_req_ready) && n < 8) begin
                tick();
                #1;
                n++;
            end
            check($sformatf("grant%0d_wait", g), (n < 8), 1);
            check($sformatf("grant%0d_ls", g), bus.ls_req_ready, (g % 5 == 4) ? 0 : 1);
            check($sformatf("grant%0d_if", g), bus.if_req_ready, (g % 5 == 4) ? 1 : 0);
            tick();
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 8) begin
            tick();
            n++;
        end
        check("grant_drain", (n < 8), 1);

        // Stalled request and delayed response
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        tick();
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h0000_0010;
        bus.ls_wen       = 1'b0;
        bus.ls_dlen      = 3'd3;
        bus.mem_rdata    = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        check("stall_ready", bus.ls_req_ready, 1);
        tick();
        bus.ls_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_resp_valid = (i == 2);
            #1;
            check($sformatf("stall_mreq%0d", i), bus.mem_req_valid, 1);
            check($sformatf("stall_maddr%0d", i), bus.mem_addr, 64'h10);
            check($sformatf("stall_mdlen%0d", i), bus.mem_dlen, 3);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        #1;
        check("stall_mreq_last", bus.mem_req_valid, 1);
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wait_mreq%0d", i), bus.mem_req_valid, 0);
            check($sformatf("wait_resp%0d", i), bus.ls_resp_valid, 0);
            tick();
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h5555_6666_7777_8888;
        tick();
        bus.mem_resp_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.ls_resp_valid) begin
                pulses++;
                check("stall_rdata", bus.ls_rdata, 64'h5555_6666_7777_8888);
            end
            tick();
        end
        check("stall_pulses", pulses, 1);

        // Asynchronous reset while waiting for the response
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 64'h0000_0000_1234_5678;
        bus.if_req_valid   = 1'b1;
        bus.if_addr        = 64'h8000_0010;
        tick();
        tick();
        #1;
        check("arst_busy_before", bus.busy, 1);
        #1;
        rst                = 1'b0;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_if_ready", bus.if_req_ready, 0);
        check("arst_mreq", bus.mem_req_valid, 0);
        check("arst_maddr", bus.mem_addr, 0);
        check("arst_mdlen", bus.mem_dlen, 0);
        check("arst_mwdata", bus.mem_wdata, 0);
        check("arst_ifdata", bus.if_rdata, 0);
        check("arst_lsdata", bus.ls_rdata, 0);
        check("arst_ifresp", bus.if_resp_valid, 0);
        tick();
        bus.if_req_valid   = 1'b0;
        bus.mem_resp_valid = 1'b0;
        tick();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.if_resp_valid || bus.ls_resp_valid)
                pulses++;
            tick();
        end
        check("arst_no_stale", pulses, 0);
        check("arst_idle", bus.busy, 0);
        txn_if("if1", 64'h8000_0020, 64'hAAAA_BBBB_0000_0073, 32'h0000_0073);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
